// File: rtl/input_debouncer.sv
// Two-flop synchronizer plus a four-state debounce FSM for one asynchronous input.
// Produces a registered debounced level and single-cycle rise/fall strobes.
module input_debouncer #(
    parameter int unsigned STABLE_CNT = 50000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic clk_i,
    input  logic nrst_i,
    input  logic en_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    typedef enum logic [1:0] {
        StLow,
        StWaitHigh,
        StHigh,
        StWaitLow
    } state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    logic             sync1_q;
    logic             sync_s_q;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;

    // Synchronizer runs regardless of en_i so a resumed FSM sees fresh data.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            sync1_q  <= 1'b0;
            sync_s_q <= 1'b0;
        end else begin
            sync1_q  <= raw_i;
            sync_s_q <= sync1_q;
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q <= StLow;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (en_i) begin
                unique case (state_q)
                    StLow: begin
                        if (sync_s_q) begin
                            state_q <= StWaitHigh;
                            cnt_q   <= CntOne;
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                    StWaitHigh: begin
                        if (!sync_s_q) begin
                            state_q <= StLow;
                            cnt_q   <= '0;
                        end else if (cnt_q == CntLast) begin
                            state_q <= StHigh;
                            cnt_q   <= '0;
                            level_q <= 1'b1;
                            rise_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CntOne;
                        end
                    end
                    StHigh: begin
                        if (!sync_s_q) begin
                            state_q <= StWaitLow;
                            cnt_q   <= CntOne;
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                    StWaitLow: begin
                        if (sync_s_q) begin
                            state_q <= StHigh;
                            cnt_q   <= '0;
                        end else if (cnt_q == CntLast) begin
                            state_q <= StLow;
                            cnt_q   <= '0;
                            level_q <= 1'b0;
                            fall_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CntOne;
                        end
                    end
                    default: begin
                        state_q <= StLow;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer: directed vector table, hand-written corner
// sequences and a randomized run against a run-length reference model.
module tb_input_debouncer;

    localparam int unsigned STABLE = 4;
    localparam int unsigned CW     = 4;

    logic clk;
    logic nrst;
    logic en;
    logic raw;
    logic level;
    logic rise;
    logic fall;

    int checks   = 0;
    int failures = 0;

    input_debouncer #(
        .STABLE_CNT(STABLE),
        .CNT_W     (CW)
    ) dut (
        .clk_i  (clk),
        .nrst_i (nrst),
        .en_i   (en),
        .raw_i  (raw),
        .level_o(level),
        .rise_o (rise),
        .fall_o (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: level flips once STABLE consecutive enabled samples of the
    // two-cycle-delayed input disagree with it; any agreeing sample clears the run.
    logic m_s1    = 1'b0;
    logic m_s2    = 1'b0;
    logic m_level = 1'b0;
    logic m_rise  = 1'b0;
    logic m_fall  = 1'b0;
    int   m_run   = 0;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_s1    <= 1'b0;
            m_s2    <= 1'b0;
            m_level <= 1'b0;
            m_rise  <= 1'b0;
            m_fall  <= 1'b0;
            m_run   <= 0;
        end else begin : mdl
            int   run;
            logic lvl;
            logic r;
            logic f;
            run = m_run;
            lvl = m_level;
            r   = 1'b0;
            f   = 1'b0;
            if (en) begin
                if (m_s2 != lvl) begin
                    run = run + 1;
                    if (run == int'(STABLE)) begin
                        lvl = ~lvl;
                        r   = lvl;
                        f   = ~lvl;
                        run = 0;
                    end
                end else begin
                    run = 0;
                end
            end
            m_run   <= run;
            m_level <= lvl;
            m_rise  <= r;
            m_fall  <= f;
            m_s2    <= m_s1;
            m_s1    <= raw;
        end
    end

    typedef struct packed {
        logic       raw;
        logic       en;
        logic [2:0] exp;  // {level, rise, fall}
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got {level,rise,fall}=%b expected=%b", name, $time, act,
                     exp);
        end
    endtask

    task automatic step(input logic r, input logic e);
        raw = r;
        en  = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        nrst = 1'b0;
        raw  = 1'b0;
        en   = 1'b1;

        // Clean press then clean release, edge-by-edge.
        for (int i = 0; i < 14; i++) begin
            if (i < 5)       tbl[i] = '{raw: 1'b1, en: 1'b1, exp: 3'b000};
            else if (i == 5) tbl[i] = '{raw: 1'b1, en: 1'b1, exp: 3'b110};
            else if (i == 6) tbl[i] = '{raw: 1'b1, en: 1'b1, exp: 3'b100};
            else if (i < 12) tbl[i] = '{raw: 1'b0, en: 1'b1, exp: 3'b100};
            else if (i == 12) tbl[i] = '{raw: 1'b0, en: 1'b1, exp: 3'b001};
            else             tbl[i] = '{raw: 1'b0, en: 1'b1, exp: 3'b000};
        end

        #12;
        chk("reset_values", {level, rise, fall}, 3'b000);
        nrst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].raw, tbl[i].en);
            chk($sformatf("table[%0d]", i), {level, rise, fall}, tbl[i].exp);
        end

        // Short pulses of width 1..3 are rejected.
        for (int w = 1; w <= 3; w++) begin
            for (int i = 0; i < 20; i++) begin
                step(i < w, 1'b1);
                chk($sformatf("glitch_w%0d[%0d]", w, i), {level, rise, fall}, 3'b000);
            end
        end

        // Enable freeze in WAIT_HIGH with cnt = 2.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1);
            chk("freeze_pre", {level, rise, fall}, 3'b000);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0);
            chk("freeze_hold", {level, rise, fall}, 3'b000);
        end
        step(1'b1, 1'b1);
        chk("freeze_resume1", {level, rise, fall}, 3'b000);
        step(1'b1, 1'b1);
        chk("freeze_rise", {level, rise, fall}, 3'b110);
        step(1'b1, 1'b1);
        chk("freeze_after", {level, rise, fall}, 3'b100);

        // Bouncy release: final 1->0 before edge 3, fall at edge 8 only.
        for (int i = 0; i < 20; i++) begin
            logic [2:0] e;
            e = (i < 8) ? 3'b100 : (i == 8) ? 3'b001 : 3'b000;
            step((i == 0) || (i == 2), 1'b1);
            chk($sformatf("bounce[%0d]", i), {level, rise, fall}, e);
        end

        // Reach level 1, then asynchronous reset with raw held high.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1);
        chk("pre_reset_level", {level, rise, fall}, 3'b100);
        #2;
        nrst = 1'b0;
        #1;
        chk("async_reset", {level, rise, fall}, 3'b000);
        #1;
        nrst = 1'b1;
        for (int i = 0; i < 7; i++) begin
            logic [2:0] e;
            e = (i < 5) ? 3'b000 : (i == 5) ? 3'b110 : 3'b100;
            step(1'b1, 1'b1);
            chk($sformatf("post_reset[%0d]", i), {level, rise, fall}, e);
        end

        // Reset during WAIT_LOW at cnt = 3 discards the pending fall.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1);
            chk("wait_low", {level, rise, fall}, 3'b100);
        end
        nrst = 1'b0;
        #1;
        chk("reset_mid_wait", {level, rise, fall}, 3'b000);
        #1;
        nrst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1);
            chk("no_fall_after_reset", {level, rise, fall}, 3'b000);
        end
        for (int i = 0; i < 7; i++) begin
            logic [2:0] e;
            e = (i < 5) ? 3'b000 : (i == 5) ? 3'b110 : 3'b100;
            step(1'b1, 1'b1);
            chk($sformatf("requalify[%0d]", i), {level, rise, fall}, e);
        end

        // Randomized run against the reference model.
        for (int i = 0; i < 3000; i++) begin
            logic r;
            logic e;
            r = ($urandom_range(0, 5) == 0) ? ~raw : raw;
            e = ($urandom_range(0, 9) != 0);
            step(r, e);
            chk("random", {level, rise, fall}, {m_level, m_rise, m_fall});
            if (rise && fall) chk("random_excl", {level, rise, fall}, {level, 2'b00});
            if ($urandom_range(0, 499) == 0) begin
                nrst = 1'b0;
                #1;
                chk("random_reset", {level, rise, fall}, {m_level, m_rise, m_fall});
                nrst = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
